// File: rtl/hazard_unit_if.sv
//------------------------------------------------------------------------------
// Module  : hazard_unit_if
// Brief   : Decode-stage hazard bundle between the pipeline control and the
//           hazard unit (ID operand/destination info in, stall/forward out).
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface hazard_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       RsD;
    logic [4:0]       RtD;
    logic             UseRsD;
    logic             UseRtD;
    logic [4:0]       WriteRegD;
    logic             RegWriteD;
    logic             MemtoRegD;
    logic [3:0]       TypeE;
    logic             StallF;
    logic             StallD;
    logic             FlushE;
    logic [CNT_W-1:0] StallCnt;

    modport master (
        output RsD, RtD, UseRsD, UseRtD, WriteRegD, RegWriteD, MemtoRegD,
        input  TypeE, StallF, StallD, FlushE, StallCnt
    );

    modport slave (
        input  RsD, RtD, UseRsD, UseRtD, WriteRegD, RegWriteD, MemtoRegD,
        output TypeE, StallF, StallD, FlushE, StallCnt
    );
endinterface

`default_nettype wire

// File: rtl/hazard_unit.sv
//------------------------------------------------------------------------------
// Module  : hazard_unit
// Brief   : Tracks EX/MEM/WB destinations, stalls on unforwardable hazards and
//           produces the registered EX forwarding code.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  wire logic     Clk,
    input  wire logic     Rst_n,
    hazard_unit_if.slave  hz
);

    // Tracking pipe: one entry per downstream stage
    logic             r_eWr, r_mWr, r_wWr;
    logic [4:0]       r_eDst, r_mDst, r_wDst;
    logic             r_eLd, r_mLd, r_wLd;
    logic [3:0]       r_typeE;
    logic [CNT_W-1:0] r_stallCnt;

    logic             w_hitA, w_luA, w_hitB, w_luB;
    logic [3:0]       w_codeA, w_codeB, w_code;
    logic             w_stall;

    // Returns {hit, loadUse, code}; base is 1 for operand A, 2 for operand B.
    // Codes step by distance: +0 d1, +4/+6 d2 (alu/load), +8/+10 d3.
    function automatic logic [5:0] f_match(input logic [4:0] src,
                                           input logic       useSrc,
                                           input logic [3:0] base);
        logic [5:0] res;
        res = '0;
        if (useSrc && (src != 5'd0)) begin
            if (r_eWr && (r_eDst == src))
                res = {1'b1, r_eLd, base};
            else if (r_mWr && (r_mDst == src))
                res = {1'b1, 1'b0, base + (r_mLd ? 4'd6 : 4'd4)};
            else if (r_wWr && (r_wDst == src))
                res = {1'b1, 1'b0, base + (r_wLd ? 4'd10 : 4'd8)};
        end
        return res;
    endfunction

    always_comb begin
        {w_hitA, w_luA, w_codeA} = f_match(hz.RsD, hz.UseRsD, 4'd1);
        {w_hitB, w_luB, w_codeB} = f_match(hz.RtD, hz.UseRtD, 4'd2);
    end

    // The EX selector can forward only one operand per cycle
    assign w_stall = w_luA || w_luB || (w_hitA && w_hitB);

    always_comb begin
        w_code = 4'd0;
        if (!w_stall) begin
            if (w_hitA)
                w_code = w_codeA;
            else if (w_hitB)
                w_code = w_codeB;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_eWr      <= 1'b0;
            r_eDst     <= 5'd0;
            r_eLd      <= 1'b0;
            r_mWr      <= 1'b0;
            r_mDst     <= 5'd0;
            r_mLd      <= 1'b0;
            r_wWr      <= 1'b0;
            r_wDst     <= 5'd0;
            r_wLd      <= 1'b0;
            r_typeE    <= 4'd0;
            r_stallCnt <= '0;
        end else begin
            r_wWr  <= r_mWr;
            r_wDst <= r_mDst;
            r_wLd  <= r_mLd;
            r_mWr  <= r_eWr;
            r_mDst <= r_eDst;
            r_mLd  <= r_eLd;
            if (w_stall) begin
                r_eWr  <= 1'b0;
                r_eDst <= 5'd0;
                r_eLd  <= 1'b0;
            end else begin
                r_eWr  <= hz.RegWriteD;
                r_eDst <= hz.WriteRegD;
                r_eLd  <= hz.MemtoRegD;
            end
            r_typeE <= w_code;
            if (w_stall && (r_stallCnt != {CNT_W{1'b1}}))
                r_stallCnt <= r_stallCnt + 1'b1;
        end
    end

    assign hz.TypeE    = r_typeE;
    assign hz.StallF   = w_stall;
    assign hz.StallD   = w_stall;
    assign hz.FlushE   = w_stall;
    assign hz.StallCnt = r_stallCnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
//------------------------------------------------------------------------------
// Module  : tb_hazard_unit
// Brief   : Directed instruction sequences for hazard_unit with a queued
//           expected-response scoreboard; a 4-bit counter copy checks saturation.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hazard_unit;

    logic Clk;
    logic Rst_n;

    hazard_unit_if #(.CNT_W(16)) hzIf ();
    hazard_unit_if #(.CNT_W(4))  satIf ();

    hazard_unit #(.CNT_W(16)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .hz    (hzIf)
    );

    hazard_unit #(.CNT_W(4)) dutSat (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .hz    (satIf)
    );

    assign satIf.RsD       = hzIf.RsD;
    assign satIf.RtD       = hzIf.RtD;
    assign satIf.UseRsD    = hzIf.UseRsD;
    assign satIf.UseRtD    = hzIf.UseRtD;
    assign satIf.WriteRegD = hzIf.WriteRegD;
    assign satIf.RegWriteD = hzIf.RegWriteD;
    assign satIf.MemtoRegD = hzIf.MemtoRegD;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       stall;
        logic [3:0] typeE;
        int         cnt;
    } exp_t;

    exp_t sb[$];
    int   nCmp = 0;
    int   nBad = 0;

    task automatic chk(input string name, input int act, input int exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every negedge with a pending expectation compares all outputs
    initial begin
        exp_t e;
        int   exp4;
        forever begin
            @(negedge Clk);
            if (sb.size() > 0) begin
                e    = sb.pop_front();
                exp4 = (e.cnt > 15) ? 15 : e.cnt;
                chk("StallF",   int'(hzIf.StallF),     int'(e.stall));
                chk("StallD",   int'(hzIf.StallD),     int'(e.stall));
                chk("FlushE",   int'(hzIf.FlushE),     int'(e.stall));
                chk("TypeE",    int'(hzIf.TypeE),      int'(e.typeE));
                chk("StallCnt", int'(hzIf.StallCnt),   e.cnt);
                chk("SatCnt",   int'(satIf.StallCnt),  exp4);
            end
        end
    end

    task automatic issue(input logic rst,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic uRs, input logic uRt,
                         input logic [4:0] dst, input logic wr, input logic ld,
                         input logic eStall, input logic [3:0] eType, input int eCnt);
        exp_t e;
        @(posedge Clk);
        #1;
        Rst_n          = rst;
        hzIf.RsD       = rs;
        hzIf.RtD       = rt;
        hzIf.UseRsD    = uRs;
        hzIf.UseRtD    = uRt;
        hzIf.WriteRegD = dst;
        hzIf.RegWriteD = wr;
        hzIf.MemtoRegD = ld;
        e.stall = eStall;
        e.typeE = eType;
        e.cnt   = eCnt;
        sb.push_back(e);
    endtask

    task automatic rop(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                       input logic eS, input logic [3:0] eT, input int eC);
        issue(1'b1, rs, rt, 1'b1, 1'b1, rd, 1'b1, 1'b0, eS, eT, eC);
    endtask

    task automatic lwop(input logic [4:0] rt, input logic [4:0] base,
                        input logic eS, input logic [3:0] eT, input int eC);
        issue(1'b1, base, 5'd0, 1'b1, 1'b0, rt, 1'b1, 1'b1, eS, eT, eC);
    endtask

    task automatic nop(input logic [3:0] eT, input int eC);
        issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, eT, eC);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n          = 1'b0;
        hzIf.RsD       = 5'd0;
        hzIf.RtD       = 5'd0;
        hzIf.UseRsD    = 1'b0;
        hzIf.UseRtD    = 1'b0;
        hzIf.WriteRegD = 5'd0;
        hzIf.RegWriteD = 1'b0;
        hzIf.MemtoRegD = 1'b0;
        repeat (2) @(posedge Clk);

        // Reset state
        issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'h0, 0);

        // ALU -> ALU at d1, operand A then operand B
        rop(5'd3, 5'd1, 5'd2, 1'b0, 4'h0, 0);
        rop(5'd4, 5'd3, 5'd5, 1'b0, 4'h0, 0);
        nop(4'h1, 0);
        rop(5'd3, 5'd1, 5'd2, 1'b0, 4'h0, 0);
        rop(5'd4, 5'd5, 5'd3, 1'b0, 4'h0, 0);
        nop(4'h2, 0);

        // Load-use: one stall, bubble, then code 7
        lwop(5'd3, 5'd1, 1'b0, 4'h0, 0);
        rop(5'd4, 5'd3, 5'd5, 1'b1, 4'h0, 0);
        rop(5'd4, 5'd3, 5'd5, 1'b0, 4'h0, 1);
        nop(4'h7, 1);

        // ALU at d2 on B, load at d3 on A
        rop(5'd3, 5'd1, 5'd2, 1'b0, 4'h0, 1);
        nop(4'h0, 1);
        rop(5'd7, 5'd5, 5'd3, 1'b0, 4'h0, 1);
        nop(4'h6, 1);
        lwop(5'd3, 5'd1, 1'b0, 4'h0, 1);
        nop(4'h0, 1);
        nop(4'h0, 1);
        rop(5'd8, 5'd3, 5'd9, 1'b0, 4'h0, 1);
        nop(4'hb, 1);

        // Dual hazard Rs==Rt: three stalls, then write-first read
        rop(5'd3, 5'd1, 5'd2, 1'b0, 4'h0, 1);
        rop(5'd6, 5'd3, 5'd3, 1'b1, 4'h0, 1);
        rop(5'd6, 5'd3, 5'd3, 1'b1, 4'h0, 2);
        rop(5'd6, 5'd3, 5'd3, 1'b1, 4'h0, 3);
        rop(5'd6, 5'd3, 5'd3, 1'b0, 4'h0, 4);
        nop(4'h0, 4);

        // $0 is never a hazard
        rop(5'd0, 5'd1, 5'd2, 1'b0, 4'h0, 4);
        rop(5'd4, 5'd0, 5'd0, 1'b0, 4'h0, 4);
        nop(4'h0, 4);

        // Load-use plus dual hazard counts once per cycle
        lwop(5'd3, 5'd1, 1'b0, 4'h0, 4);
        rop(5'd6, 5'd3, 5'd3, 1'b1, 4'h0, 4);
        rop(5'd6, 5'd3, 5'd3, 1'b1, 4'h0, 5);
        rop(5'd6, 5'd3, 5'd3, 1'b1, 4'h0, 6);
        rop(5'd6, 5'd3, 5'd3, 1'b0, 4'h0, 7);
        nop(4'h0, 7);

        // Load-use on operand B, then code 8
        lwop(5'd5, 5'd1, 1'b0, 4'h0, 7);
        rop(5'd4, 5'd1, 5'd5, 1'b1, 4'h0, 7);
        rop(5'd4, 5'd1, 5'd5, 1'b0, 4'h0, 8);
        nop(4'h8, 8);

        // Reset mid-sequence clears a pending load-use
        lwop(5'd3, 5'd1, 1'b0, 4'h0, 8);
        issue(1'b0, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 4'h0, 0);
        issue(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 4'h0, 0);
        nop(4'h0, 0);

        // Twenty load-use stalls: the 4-bit counter must stick at 15
        for (int i = 0; i < 20; i++) begin
            lwop(5'd3, 5'd1, 1'b0, (i == 0) ? 4'h0 : 4'h7, i);
            rop(5'd4, 5'd3, 5'd5, 1'b1, 4'h0, i);
            rop(5'd4, 5'd3, 5'd5, 1'b0, 4'h0, i + 1);
        end
        nop(4'h7, 20);

        @(posedge Clk);
        @(negedge Clk);
        #1;
        if (sb.size() != 0) begin
            nBad++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_unit.md
# hazard_unit

Decode-stage hazard detector for the five-stage pipelined MIPS core. It tracks the destination registers of the instructions in EX, MEM and WB, and compares them against the source registers of the instruction in ID. From that it does two things: it stalls fetch/decode and injects an EX bubble when forwarding cannot resolve the dependency, and it produces the registered 4-bit forwarding `type` code that the EX-stage operand selector consumes in the same cycle the instruction executes.

## Interface
Parameters
- `CNT_W`, default 16: width of the saturating stall counter.

Ports
- `Clk` in 1: the only clock. All state updates on its rising edge.
- `Rst_n` in 1: reset, asynchronous, active-low.
- `RsD` in 5: first source register of the ID instruction.
- `RtD` in 5: second source register of the ID instruction.
- `UseRsD` in 1: ID instruction reads Rs.
- `UseRtD` in 1: ID instruction reads Rt.
- `WriteRegD` in 5: destination register of the ID instruction.
- `RegWriteD` in 1: ID instruction writes the register file.
- `MemtoRegD` in 1: ID instruction is a load.
- `TypeE` out 4: registered forwarding code, valid while the instruction is in EX.
- `StallF` out 1: hold the PC.
- `StallD` out 1: hold the IF/ID register.
- `FlushE` out 1: load a bubble into ID/EX.
- `StallCnt` out CNT_W: number of stall cycles since reset; saturates at all-ones.

## Operation
- Tracking pipe has three entries: E, M, W. Each entry holds {wr, dst[4:0], ld}.
  - Each cycle, W←M and M←E.
  - E←{RegWriteD, WriteRegD, MemtoRegD} when `stall`=0. E←{0,0,0} (a bubble) when `stall`=1.
- Operand match, evaluated combinationally in ID, separately for Rs (operand A) and Rt (operand B):
  - An operand matches only if its Use bit is 1 and its register is non-zero.
  - The match is against an entry with wr=1 and an equal dst.
  - Nearest entry wins: E has distance 1, M distance 2, W distance 3.
  - Distance is measured at the time the consumer reaches EX.
- Per-operand code. The A code is used when only A hazards; the B code when only B hazards.
  - R-type producer (ld=0): d1 → 1/2, d2 → 5/6, d3 → 9/a.
  - Load producer (ld=1): d2 → 7/8, d3 → b/c.
  - Load at d1 means a load-use hazard; codes 3/4 are never emitted.
- `stall`=1 if either condition holds:
  - either operand has a load-use hazard at d1, or
  - both operands hazard at any distance, including Rs==Rt. The selector forwards only one operand per cycle.
- Stall effects:
  - StallF=StallD=FlushE=`stall`; all three are combinational.
  - StallCnt increments by 1 per stall cycle, saturating.
- The ID instruction re-evaluates every stalled cycle, because the producers advance one stage per cycle. The stall releases once a single forwardable hazard or no hazard remains.
- Distance 4 and beyond gives no hazard. The register file is write-first, so the value is read directly.
- TypeE:
  - On the next edge, TypeE←code when `stall`=0.
  - TypeE←0 when `stall`=1, matching the bubble.
  - No hazard gives 0.

## Timing
- Reset (`Rst_n`=0, asynchronous):
  - E/M/W entries clear to {0,0,0}.
  - TypeE=0 and StallCnt=0.
  - StallF/StallD/FlushE=0, since no hazard can exist with empty entries.
- Latency:
  - Stall outputs take zero cycles, combinational from D inputs and tracking state.
  - TypeE appears one cycle after the decision, aligned with the instruction's EX cycle.
- Load-use stalls exactly one cycle. After the stall, the load is at d2 and the code is 7/8.
- Worst-case dual hazard (both at d1) stalls 3 cycles until both producers pass W.
- Reset deasserted mid-program: the first instruction after reset is treated as having no producers.
- Simultaneous load-use on A and dual hazard: a single `stall`. StallCnt counts it once.
- StallCnt at all-ones stays all-ones.

## Test plan
- `add $3,$1,$2` then `sub $4,$3,$5` → no stall; TypeE=1 in sub's EX cycle. Repeat with `sub $4,$5,$3` → TypeE=2.
- `lw $3,0($1)` then `add $4,$3,$5` → StallF/StallD/FlushE=1 for exactly 1 cycle, TypeE=0 for the bubble, then TypeE=7; StallCnt=1.
- Producer `add $3` followed by one independent instruction, then a consumer of $3 as Rt → TypeE=6. With two independent instructions in between and a `lw` producer, consumer as Rs → TypeE=b.
- `add $3`, then `add $6,$3,$3` → 3 stall cycles, TypeE=0 throughout, then 0 (write-first read); StallCnt=3.
- Producer writing $0, then a consumer reading $0 → no stall, TypeE=0. Assert `Rst_n` low mid-sequence → all outputs 0 immediately, no stall on the first instruction after release.
- Force CNT_W=4 and generate 20 load-use stalls → StallCnt holds at 15.
